// File: rtl/hsv_pkg.sv
// Shared color-detect definitions: function/format codes and the channel expansion helper.
package hsv_pkg;

    localparam logic [1:0] FN_NONE  = 2'd0;
    localparam logic [1:0] FN_RED   = 2'd1;
    localparam logic [1:0] FN_GREEN = 2'd2;
    localparam logic [1:0] FN_BLUE  = 2'd3;

    localparam int FMT_RGB565 = 0;
    localparam int FMT_RGB888 = 1;

    localparam int EXP_W = 32;

    // Left-align an fw-bit field into cw bits, zero-padding the LSBs; requires cw >= fw.
    function automatic logic [EXP_W-1:0] expand_ch(input logic [7:0] field, input int fw, input int cw);
        logic [EXP_W-1:0] f;
        f = EXP_W'(field) & ((EXP_W'(1) << fw) - EXP_W'(1));
        return f << (cw - fw);
    endfunction

endpackage

// File: rtl/hsv_minmax.sv
// Combinational max/min and dominant-channel select with red > green > blue tie-break.
module hsv_minmax
    import hsv_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic [CW-1:0] r,
    input  logic [CW-1:0] g,
    input  logic [CW-1:0] b,
    output logic [CW-1:0] max_val,
    output logic [CW-1:0] min_val,
    output logic [1:0]    fn
);

    always_comb begin
        fn      = FN_BLUE;
        max_val = b;
        if (r >= g && r >= b) begin
            fn      = FN_RED;
            max_val = r;
        end else if (g >= r && g >= b) begin
            fn      = FN_GREEN;
            max_val = g;
        end
    end

    always_comb begin
        min_val = r;
        if (g < min_val) min_val = g;
        if (b < min_val) min_val = b;
    end

endmodule

// File: rtl/hsv_prep.sv
// RGB565/RGB888 to HSV divider front end: two-stage back-pressurable pipeline.
// Optional saturation outputs are built when HSV_PREP_SAT_EN is defined.
module hsv_prep
    import hsv_pkg::*;
#(
    parameter int CW     = 8,
    parameter int FMT    = 0,
    parameter int USER_W = 1
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic [23:0]       i_data,
    input  logic [USER_W-1:0] i_user,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [CW:0]       o_dividend,
    output logic [CW:0]       o_divisor,
    output logic [CW-1:0]     o_value,
    output logic [1:0]        o_function,
    output logic              o_gray,
    output logic [USER_W-1:0] o_user,
    output logic              o_valid,
`ifdef HSV_PREP_SAT_EN
    output logic [CW-1:0]     o_sat_num,
    output logic [CW-1:0]     o_sat_den,
`endif
    input  logic              i_ready
);

    logic [CW-1:0] r_x, g_x, b_x;
    logic [CW-1:0] mm_max, mm_min;
    logic [1:0]    mm_fn;

    generate
        if (FMT == FMT_RGB888) begin : g_888
            assign r_x = CW'(expand_ch(i_data[23:16], 8, CW));
            assign g_x = CW'(expand_ch(i_data[15:8],  8, CW));
            assign b_x = CW'(expand_ch(i_data[7:0],   8, CW));
        end else begin : g_565
            logic unused_hi;
            assign unused_hi = ^i_data[23:16];
            assign r_x = CW'(expand_ch({3'b000, i_data[15:11]}, 5, CW));
            assign g_x = CW'(expand_ch({2'b00,  i_data[10:5]},  6, CW));
            assign b_x = CW'(expand_ch({3'b000, i_data[4:0]},   5, CW));
        end
    endgenerate

    hsv_minmax #(.CW(CW)) u_minmax (
        .r       (r_x),
        .g       (g_x),
        .b       (b_x),
        .max_val (mm_max),
        .min_val (mm_min),
        .fn      (mm_fn)
    );

    logic              s1_valid;
    logic [CW-1:0]     s1_r, s1_g, s1_b, s1_max, s1_min;
    logic [1:0]        s1_fn;
    logic [USER_W-1:0] s1_user;

    logic              s2_valid;
    logic [CW:0]       s2_dividend, s2_divisor;
    logic [CW-1:0]     s2_value;
    logic [1:0]        s2_fn;
    logic              s2_gray;
    logic [USER_W-1:0] s2_user;

    logic adv1, adv2;

    assign adv2    = !s2_valid || i_ready;
    assign adv1    = !s1_valid || adv2;
    assign o_ready = adv1 && i_rstn;

    // Zero-extend before subtracting so the dividend never overflows.
    logic [CW:0] r_e, g_e, b_e, dividend_c;
    assign r_e = {1'b0, s1_r};
    assign g_e = {1'b0, s1_g};
    assign b_e = {1'b0, s1_b};

    always_comb begin
        dividend_c = g_e - b_e;
        case (s1_fn)
            FN_GREEN: dividend_c = b_e - r_e;
            FN_BLUE:  dividend_c = r_e - g_e;
            default:  dividend_c = g_e - b_e;
        endcase
    end

`ifdef HSV_PREP_SAT_EN
    logic [CW-1:0] s2_sat_num, s2_sat_den;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            s1_valid    <= 1'b0;
            s1_r        <= '0;
            s1_g        <= '0;
            s1_b        <= '0;
            s1_max      <= '0;
            s1_min      <= '0;
            s1_fn       <= FN_NONE;
            s1_user     <= '0;
            s2_valid    <= 1'b0;
            s2_dividend <= '0;
            s2_divisor  <= '0;
            s2_value    <= '0;
            s2_fn       <= FN_NONE;
            s2_gray     <= 1'b0;
            s2_user     <= '0;
`ifdef HSV_PREP_SAT_EN
            s2_sat_num  <= '0;
            s2_sat_den  <= '0;
`endif
        end else begin
            if (adv1) begin
                s1_valid <= i_valid;
                if (i_valid) begin
                    s1_r    <= r_x;
                    s1_g    <= g_x;
                    s1_b    <= b_x;
                    s1_max  <= mm_max;
                    s1_min  <= mm_min;
                    s1_fn   <= mm_fn;
                    s1_user <= i_user;
                end
            end
            if (adv2) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_dividend <= dividend_c;
                    s2_divisor  <= {1'b0, s1_max - s1_min};
                    s2_value    <= s1_max;
                    s2_fn       <= s1_fn;
                    s2_gray     <= (s1_max == s1_min);
                    s2_user     <= s1_user;
`ifdef HSV_PREP_SAT_EN
                    s2_sat_num  <= s1_max - s1_min;
                    s2_sat_den  <= s1_max;
`endif
                end
            end
        end
    end

    assign o_valid    = s2_valid;
    assign o_dividend = s2_dividend;
    assign o_divisor  = s2_divisor;
    assign o_value    = s2_value;
    assign o_function = s2_fn;
    assign o_gray     = s2_gray;
    assign o_user     = s2_user;
`ifdef HSV_PREP_SAT_EN
    assign o_sat_num  = s2_sat_num;
    assign o_sat_den  = s2_sat_den;
`endif

endmodule

// File: tb/tb_hsv_prep.sv
// Directed bench for hsv_prep: one RGB565 and one RGB888 instance, CW=8.
// Checks the saturation outputs too when HSV_PREP_SAT_EN is defined.
module tb_hsv_prep;

    logic        clk = 1'b0;
    logic        rstn;
    logic [23:0] data;
    logic [2:0]  user;
    logic        v0, v1, rdy;
    logic        sel;

    logic       o0_ready, o0_valid, o0_gray, o1_ready, o1_valid, o1_gray;
    logic [8:0] o0_div, o0_dvs, o1_div, o1_dvs;
    logic [7:0] o0_v, o1_v;
    logic [1:0] o0_fn, o1_fn;
    logic [2:0] o0_user, o1_user;
`ifdef HSV_PREP_SAT_EN
    logic [7:0] o0_sn, o0_sd, o1_sn, o1_sd;
`endif

    always #5 clk = ~clk;

    hsv_prep #(.CW(8), .FMT(0), .USER_W(3)) u565 (
        .i_clk(clk), .i_rstn(rstn), .i_data(data), .i_user(user), .i_valid(v0),
        .o_ready(o0_ready), .o_dividend(o0_div), .o_divisor(o0_dvs), .o_value(o0_v),
        .o_function(o0_fn), .o_gray(o0_gray), .o_user(o0_user), .o_valid(o0_valid),
`ifdef HSV_PREP_SAT_EN
        .o_sat_num(o0_sn), .o_sat_den(o0_sd),
`endif
        .i_ready(rdy)
    );

    hsv_prep #(.CW(8), .FMT(1), .USER_W(3)) u888 (
        .i_clk(clk), .i_rstn(rstn), .i_data(data), .i_user(user), .i_valid(v1),
        .o_ready(o1_ready), .o_dividend(o1_div), .o_divisor(o1_dvs), .o_value(o1_v),
        .o_function(o1_fn), .o_gray(o1_gray), .o_user(o1_user), .o_valid(o1_valid),
`ifdef HSV_PREP_SAT_EN
        .o_sat_num(o1_sn), .o_sat_den(o1_sd),
`endif
        .i_ready(rdy)
    );

    logic       m_valid, m_gray;
    logic [8:0] m_div, m_dvs;
    logic [7:0] m_v;
    logic [1:0] m_fn;
    logic [2:0] m_user;
    assign m_valid = sel ? o1_valid : o0_valid;
    assign m_gray  = sel ? o1_gray  : o0_gray;
    assign m_div   = sel ? o1_div   : o0_div;
    assign m_dvs   = sel ? o1_dvs   : o0_dvs;
    assign m_v     = sel ? o1_v     : o0_v;
    assign m_fn    = sel ? o1_fn    : o0_fn;
    assign m_user  = sel ? o1_user  : o0_user;
`ifdef HSV_PREP_SAT_EN
    logic [7:0] m_sn, m_sd;
    assign m_sn = sel ? o1_sn : o0_sn;
    assign m_sd = sel ? o1_sd : o0_sd;
`endif

    typedef struct {
        logic        fmt;
        logic [23:0] data;
        logic [1:0]  fn;
        logic [8:0]  div;
        logic [8:0]  dvs;
        logic [7:0]  v;
        logic        gray;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs[NV];

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    // Sends one pixel into the selected instance and checks its result and 2-cycle latency.
    task automatic apply_vec(input vec_t vc, input logic [2:0] u);
        int k;
        @(posedge clk); #1;
        sel  = vc.fmt;
        data = vc.data;
        user = u;
        rdy  = 1'b1;
        if (vc.fmt) v1 = 1'b1; else v0 = 1'b1;
        @(posedge clk); #1;
        v0 = 1'b0;
        v1 = 1'b0;
        k = 0;
        while (k < 8) begin
            @(negedge clk);
            if (m_valid) break;
            k++;
        end
        if (k >= 8) begin
            chk("timeout", 32'd0, 32'd1);
        end else begin
            chk("latency", k, 1);
            chk("function", m_fn, vc.fn);
            chk("dividend", m_div, vc.div);
            chk("divisor", m_dvs, vc.dvs);
            chk("value", m_v, vc.v);
            chk("gray", m_gray, vc.gray);
            chk("user", m_user, u);
`ifdef HSV_PREP_SAT_EN
            chk("sat_num", m_sn, vc.dvs[7:0]);
            chk("sat_den", m_sd, vc.v);
`endif
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0, 24'h00F800, 2'd1, 9'h000, 9'd248, 8'd248, 1'b0};
        vecs[1]  = '{1'b0, 24'h0007E0, 2'd2, 9'h000, 9'd252, 8'd252, 1'b0};
        vecs[2]  = '{1'b0, 24'h00001F, 2'd3, 9'h000, 9'd248, 8'd248, 1'b0};
        vecs[3]  = '{1'b0, 24'h00FFE0, 2'd2, 9'h108, 9'd252, 8'd252, 1'b0};
        vecs[4]  = '{1'b0, 24'h000000, 2'd1, 9'h000, 9'd0,   8'd0,   1'b1};
        vecs[5]  = '{1'b1, 24'h3080C0, 2'd3, 9'h1B0, 9'd144, 8'd192, 1'b0};
        vecs[6]  = '{1'b1, 24'hFFFFFF, 2'd1, 9'h000, 9'd0,   8'd255, 1'b1};
        vecs[7]  = '{1'b1, 24'hFF00FF, 2'd1, 9'h101, 9'd255, 8'd255, 1'b0};
        vecs[8]  = '{1'b1, 24'hFFFF00, 2'd1, 9'h0FF, 9'd255, 8'd255, 1'b0};
        vecs[9]  = '{1'b0, 24'h0007FF, 2'd2, 9'h0F8, 9'd252, 8'd252, 1'b0};
        vecs[10] = '{1'b0, 24'hFF0000, 2'd1, 9'h000, 9'd0,   8'd0,   1'b1};
        vecs[11] = '{1'b1, 24'h102030, 2'd3, 9'h1F0, 9'd32,  8'd48,  1'b0};

        rstn = 1'b0; data = '0; user = '0; v0 = 1'b0; v1 = 1'b0; rdy = 1'b1; sel = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", o0_ready, 0);
        chk("rst_valid", o0_valid, 0);
        chk("rst_value", o1_v, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", o0_ready, 1);

        for (int i = 0; i < NV; i++) apply_vec(vecs[i], 3'(i));

        // Back-pressure: 6 pixels, i_ready low in cycles 3..6.
        begin
            int nxt = 0, emit = 0, infl = 0;
            logic stall_prev = 1'b0;
            logic [8:0] sv_div;
            logic [7:0] sv_v;
            logic [2:0] sv_u;
            logic acc, emt;
            sel = 1'b0;
            for (int c = 0; c < 40 && emit < 6; c++) begin
                @(posedge clk); #1;
                rdy  = !(c >= 3 && c <= 6);
                v0   = (nxt < 6);
                data = {8'h00, 5'(nxt + 1), 11'h000};
                user = 3'(nxt);
                @(negedge clk);
                chk("bp_ready", o0_ready, !(infl == 2 && !rdy));
                if (stall_prev) begin
                    chk("stall_value", o0_v, sv_v);
                    chk("stall_user", o0_user, sv_u);
                    chk("stall_div", o0_div, sv_div);
                end
                stall_prev = o0_valid && !rdy;
                sv_v = o0_v; sv_u = o0_user; sv_div = o0_div;
                acc = v0 && o0_ready;
                emt = o0_valid && rdy;
                if (emt) begin
                    chk("bp_user", o0_user, emit);
                    chk("bp_value", o0_v, (emit + 1) * 8);
                    emit++;
                end
                if (acc) nxt++;
                infl = infl + int'(acc) - int'(emt);
            end
            chk("bp_count", emit, 6);
            @(posedge clk); #1;
            v0 = 1'b0;
        end

        // Reset mid-stream with two pixels held in flight.
        begin
            int seen = 0;
            sel = 1'b0;
            rdy = 1'b0;
            @(posedge clk); #1;
            v0 = 1'b1; data = 24'h00F800; user = 3'd5;
            @(posedge clk); #1;
            data = 24'h0007E0; user = 3'd6;
            @(posedge clk); #1;
            @(negedge clk);
            chk("mid_inflight", o0_valid, 1);
            @(posedge clk); #1;
            rstn = 1'b0;
            @(negedge clk);
            chk("mid_rst_ready", o0_ready, 0);
            @(posedge clk);
            @(negedge clk);
            chk("mid_rst_valid", o0_valid, 0);
            chk("mid_rst_div", o0_div, 0);
            chk("mid_rst_dvs", o0_dvs, 0);
            chk("mid_rst_value", o0_v, 0);
            chk("mid_rst_fn", o0_fn, 0);
            chk("mid_rst_gray", o0_gray, 0);
            chk("mid_rst_user", o0_user, 0);
            @(posedge clk); #1;
            rstn = 1'b1; v0 = 1'b0; rdy = 1'b1;
            @(negedge clk);
            chk("mid_rel_ready", o0_ready, 1);
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (o0_valid) seen++;
            end
            chk("mid_no_emit", seen, 0);
            apply_vec(vecs[2], 3'd2);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hsv_prep.md
# hsv_prep

Parametrised RGB-to-HSV front end that sits between the pixel source and the divider generator IP in the color-detect pipeline. It accepts packed RGB565 or RGB888 pixels over a valid/ready handshake and expands each channel to a configurable width. It identifies the dominant channel and produces the signed hue dividend, unsigned divisor, value (V) and a gray flag through a two-stage, back-pressurable pipeline with a sideband passthrough.

## Interface
- CW, 8: internal channel width in bits; must be ≥6, and ≥8 when FMT=1.
- FMT, 0: input format; 0 = RGB565 in i_data[15:0] (R[15:11] G[10:5] B[4:0]); 1 = RGB888 (R[23:16] G[15:8] B[7:0]).
- USER_W, 1: sideband width (e.g. SOF/EOL), carried alongside the pixel.
- i_clk  in  1  clock.
- i_rstn  in  1  reset, synchronous, active-low.
- i_data  in  24  packed pixel; bits [23:16] are ignored when FMT=0.
- i_user  in  USER_W  sideband, sampled with i_data.
- i_valid  in  1  input pixel valid.
- o_ready  out  1  input accepted when i_valid && o_ready.
- o_dividend  out  CW+1  signed hue dividend, two's complement.
- o_divisor  out  CW+1  unsigned max−min, MSB always 0.
- o_value  out  CW  V = max channel.
- o_function  out  2  dominant channel: 0 none, 1 red, 2 green, 3 blue.
- o_gray  out  1  max==min, so the divisor is 0.
- o_user  out  USER_W  sideband aligned with the result.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream ready; transfer occurs on o_valid && i_ready.

## Operation
- Channel expansion: each field is left-aligned into CW bits and the LSBs are zero-padded. With CW=8, RGB565 gives R<<3, G<<2, B<<3.
- Stage 1 (S1) registers the expanded r, g, b values, max, min, function and user.
- Dominant channel selection, with ties resolved red > green > blue:
  - Red: r≥g && r≥b → function 1, dividend = g−b.
  - Green: else if g≥r && g≥b → function 2, dividend = b−r.
  - Blue: otherwise → function 3, dividend = r−g.
- Stage 2 (S2) registers dividend, divisor = max−min, value = max, gray = (max==min), plus function and user.
- Arithmetic: channels are zero-extended to CW+1 bits before subtracting. The dividend ranges from −(2^CW−1) to 2^CW−1 and never overflows.
- Gray pixel: output is function 1, dividend 0, divisor 0, o_gray=1. Downstream must bypass the divide.
- Handshake:
  - adv2 = !s2_valid || i_ready.
  - adv1 = !s1_valid || adv2.
  - o_ready = adv1 && i_rstn.
  - The i_ready→o_ready combinational path is permitted.
- Stall: while o_valid && !i_ready, every output holds stable. Neither stage may drop or duplicate a pixel.
- Order: strict FIFO; there is no reordering.

## Timing
- Latency: 2 cycles from input acceptance to o_valid, when i_ready is high.
- Throughput: 1 pixel/cycle sustained.
- Buffering: at most 2 pixels in flight. o_ready falls in the same cycle as i_ready when both stages are full.
- Reset (i_rstn low at a clock edge):
  - Both stage valids clear; all outputs go to 0 (o_valid, o_dividend, o_divisor, o_value, o_function, o_gray, o_user).
  - o_ready is 0 during reset and 1 in the first cycle after.
- Reset mid-stream: in-flight pixels are discarded without emission. An i_valid asserted during reset is not accepted.
- Simultaneous accept and emit with both stages full: S2 emits, S1 moves to S2, and the new pixel enters S1 in the same cycle.

## Configuration
- HSV_PREP_SAT_EN defined: adds ports o_sat_num (CW, = max−min) and o_sat_den (CW, = max), registered in S2 with the same stall and reset-to-0 rules. Gray pixels give num=0. Black gives den=0, which downstream forces S=0.
- HSV_PREP_SAT_EN undefined: these ports and their registers do not exist, and the other behaviour is unchanged.

## Structure
- Package hsv_pkg holds:
  - function codes FN_NONE=0, FN_RED=1, FN_GREEN=2, FN_BLUE=3;
  - format codes FMT_RGB565=0, FMT_RGB888=1;
  - the channel-expansion function, shared with the other color-detect blocks.
- Sub-module hsv_minmax (combinational, parameter CW): takes r, g, b and outputs max, min and function with the fixed tie-break. It is instantiated in S1.

## Test plan
- Primaries, FMT=0, CW=8:
  - 0xF800 → fn1, div 0, dvs 248, V 248, gray 0.
  - 0x07E0 → fn2, div 0, dvs 252, V 252.
  - 0x001F → fn3, div 0, dvs 248, V 248.
- Yellow 0xFFE0 (r248 g252 b0) → fn2, dividend −248 (9'h108), dvs 252, V 252. Gray 0x0000 → fn1, div 0, dvs 0, V 0, gray 1.
- FMT=1, 0x3080C0 (r48 g128 b192) → fn3, dividend −80 (9'h1B0), dvs 144, V 192.
- Back-pressure:
  - Stimulus: stream 6 pixels with user=idx, hold i_ready low for cycles 3–6.
  - Response: o_ready low while both stages are full, outputs stable, all 6 emitted in order with matching o_user.
- Reset mid-stream: pull i_rstn low with 2 pixels in flight → nothing emitted, all outputs 0. o_ready=1 on the first cycle after release. The next pixel appears 2 cycles after acceptance.
- With HSV_PREP_SAT_EN, 0x3080C0 (FMT=1) → sat_num 144, sat_den 192. Gray 0x0000 → 0/0.
